// File: rtl/conv_pkg.sv
// Shared definitions for conv_complex and the blocks that consume its output.
//   WORD_LENGTH  : default word width (QI+QF) of one real or imaginary part
//   conv_state_e : serializer FSM state encoding (StIdle, StSend)
//   slot_lsb()   : bit offset of complex slot k in a packed result bus
package conv_pkg;

    localparam int unsigned QI_DEFAULT  = 4;
    localparam int unsigned QF_DEFAULT  = 4;
    localparam int unsigned WORD_LENGTH = QI_DEFAULT + QF_DEFAULT;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StSend = 1'b1
    } conv_state_e;

    // Slot k holds {re, im}, each w bits wide, with slot 0 least significant.
    function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned w);
        return 2 * w * k;
    endfunction

endpackage

// File: rtl/conv_frame_reg.sv
// Capture register for one conv_complex result frame (packed bus + overflow bit).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears to 0)
//   load_i    : capture data_i/ovf_i on this edge
//   data_i    : packed frame to capture
//   ovf_i     : overflow flag travelling with the frame
//   data_o    : held frame
//   ovf_o     : held overflow flag
module conv_frame_reg #(
    parameter int unsigned Width = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    input  logic             ovf_i,
    output logic [Width-1:0] data_o,
    output logic             ovf_o
);

    logic [Width-1:0] data_d, data_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        data_d = data_q;
        ovf_d  = ovf_q;
        if (load_i) begin
            data_d = data_i;
            ovf_d  = ovf_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            ovf_q  <= ovf_d;
        end
    end

    assign data_o = data_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/conv_complex_serializer.sv
// Output-side reader for conv_complex. Captures a packed result frame on the rising
// edge of conv_done and streams it one complex sample per valid/ready beat. One frame
// is active while a second may wait in a one-deep pending slot; a frame arriving while
// both are occupied is dropped and reported on frame_dropped.
// Optional feature: define CONV_SER_DROP_CNT_EN to add drop_count, a saturating
// 8-bit count of dropped frames cleared only by rst.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   conv_in        : packed result bus, OUT_LEN slots of {re, im}
//   conv_overflow  : overflow flag sampled with conv_in
//   conv_done      : done level; a frame is taken on its rising edge
//   m_valid/m_ready: output handshake
//   m_re, m_im     : current sample
//   m_index        : sample index within frame
//   m_last         : final beat of the frame
//   m_overflow     : overflow flag of the frame being sent
//   busy           : a frame is being sent
//   frame_dropped  : one-cycle pulse when an arriving frame is discarded
//   drop_count     : (CONV_SER_DROP_CNT_EN only) saturating drop counter
module conv_complex_serializer
    import conv_pkg::*;
#(
    parameter int unsigned QI        = 4,
    parameter int unsigned QF        = 4,
    parameter int unsigned NUM_ELEMS = 3,
    parameter int unsigned IDX_W     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [2*(QI+QF)*(NUM_ELEMS+2)-1:0]     conv_in,
    input  logic                                   conv_overflow,
    input  logic                                   conv_done,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [QI+QF-1:0]                       m_re,
    output logic [QI+QF-1:0]                       m_im,
    output logic [IDX_W-1:0]                       m_index,
    output logic                                   m_last,
    output logic                                   m_overflow,
    output logic                                   busy,
    output logic                                   frame_dropped
`ifdef CONV_SER_DROP_CNT_EN
    ,
    output logic [7:0]                             drop_count
`endif
);

    localparam int unsigned W       = QI + QF;
    localparam int unsigned OUT_LEN = NUM_ELEMS + 2;
    localparam int unsigned BUS_W   = 2 * W * OUT_LEN;

    conv_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q;
    logic             pend_valid_q, pend_valid_d;
    logic             drop_q, drop_d;

    logic             active_load, active_from_pend, pend_load;
    logic [BUS_W-1:0] active_data, pend_data, active_src;
    logic             active_ovf, pend_ovf, active_src_ovf;

    logic             capture, beat, at_last;
    logic [2*W-1:0]   slot;

    assign capture = conv_done & ~done_q;
    assign beat    = (state_q == StSend) & m_ready;
    assign at_last = (idx_q == IDX_W'(OUT_LEN - 1));

    // Active frame is refilled either from the pending slot or straight from the bus.
    assign active_src     = active_from_pend ? pend_data : conv_in;
    assign active_src_ovf = active_from_pend ? pend_ovf  : conv_overflow;

    conv_frame_reg #(
        .Width (BUS_W)
    ) u_active (
        .clk    (clk),
        .rst    (rst),
        .load_i (active_load),
        .data_i (active_src),
        .ovf_i  (active_src_ovf),
        .data_o (active_data),
        .ovf_o  (active_ovf)
    );

    conv_frame_reg #(
        .Width (BUS_W)
    ) u_pending (
        .clk    (clk),
        .rst    (rst),
        .load_i (pend_load),
        .data_i (conv_in),
        .ovf_i  (conv_overflow),
        .data_o (pend_data),
        .ovf_o  (pend_ovf)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            done_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            done_q       <= conv_done;
            pend_valid_q <= pend_valid_d;
            drop_q       <= drop_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        pend_valid_d     = pend_valid_q;
        drop_d           = 1'b0;
        active_load      = 1'b0;
        active_from_pend = 1'b0;
        pend_load        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    active_load = 1'b1;
                    idx_d       = '0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (beat && at_last) begin
                    idx_d = '0;
                    if (pend_valid_q) begin
                        // Promote pending; a coincident capture takes its place.
                        active_load      = 1'b1;
                        active_from_pend = 1'b1;
                        pend_load        = capture;
                        pend_valid_d     = capture;
                    end else if (capture) begin
                        active_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (beat) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (capture) begin
                        if (pend_valid_q) begin
                            drop_d = 1'b1;
                        end else begin
                            pend_load    = 1'b1;
                            pend_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Slot mux: constant part-selects keyed by the current index.
    always_comb begin
        slot = '0;
        for (int unsigned k = 0; k < OUT_LEN; k++) begin
            if (idx_q == IDX_W'(k)) begin
                slot = active_data[slot_lsb(k, W) +: 2*W];
            end
        end
    end

    // Outputs; sample fields are forced to zero outside SEND.
    always_comb begin
        m_valid       = (state_q == StSend);
        busy          = m_valid;
        m_re          = m_valid ? slot[2*W-1:W] : '0;
        m_im          = m_valid ? slot[W-1:0]   : '0;
        m_index       = m_valid ? idx_q         : '0;
        m_last        = m_valid & at_last;
        m_overflow    = m_valid & active_ovf;
        frame_dropped = drop_q;
    end

`ifdef CONV_SER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_conv_complex_serializer.sv
module tb_conv_complex_serializer;

    localparam int unsigned QI        = 4;
    localparam int unsigned QF        = 4;
    localparam int unsigned NUM_ELEMS = 3;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned W         = QI + QF;
    localparam int unsigned OUT_LEN   = NUM_ELEMS + 2;
    localparam int unsigned BUS_W     = 2 * W * OUT_LEN;

    logic             clk = 1'b0;
    logic             rst;
    logic [BUS_W-1:0] conv_in;
    logic             conv_overflow;
    logic             conv_done;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_re;
    logic [W-1:0]     m_im;
    logic [IDX_W-1:0] m_index;
    logic             m_last;
    logic             m_overflow;
    logic             busy;
    logic             frame_dropped;
`ifdef CONV_SER_DROP_CNT_EN
    logic [7:0]       drop_count;
`endif

    always #5 clk = ~clk;

    conv_complex_serializer #(
        .QI        (QI),
        .QF        (QF),
        .NUM_ELEMS (NUM_ELEMS),
        .IDX_W     (IDX_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .conv_in       (conv_in),
        .conv_overflow (conv_overflow),
        .conv_done     (conv_done),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_re          (m_re),
        .m_im          (m_im),
        .m_index       (m_index),
        .m_last        (m_last),
        .m_overflow    (m_overflow),
        .busy          (busy),
        .frame_dropped (frame_dropped)
`ifdef CONV_SER_DROP_CNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    // Reference model: a queue of frames still to be sent (head = active, at most two)
    // plus the position within the head frame.
    typedef struct packed {
        logic [BUS_W-1:0] data;
        logic             ovf;
    } frame_t;

    frame_t      mq[$];
    int unsigned midx;
    logic        mdone_prev;
    logic        mdrop;
    int unsigned mcnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output with what the model says it must be right now.
    task automatic compare();
        logic [BUS_W-1:0] sh;
        logic             v;
        logic [W-1:0]     ere, eim;
        v   = (mq.size() != 0);
        ere = '0;
        eim = '0;
        if (v) begin
            sh  = mq[0].data >> (midx * 2 * W);
            ere = sh[2*W-1:W];
            eim = sh[W-1:0];
        end
        chk("m_valid", 32'(m_valid), 32'(v));
        chk("busy", 32'(busy), 32'(v));
        chk("m_re", 32'(m_re), 32'(ere));
        chk("m_im", 32'(m_im), 32'(eim));
        chk("m_index", 32'(m_index), v ? midx : 32'd0);
        chk("m_last", 32'(m_last), 32'(v && (midx == OUT_LEN - 1)));
        chk("m_overflow", 32'(m_overflow), 32'(v && mq[0].ovf));
        chk("frame_dropped", 32'(frame_dropped), 32'(mdrop));
`ifdef CONV_SER_DROP_CNT_EN
        chk("drop_count", 32'(drop_count), mcnt);
`endif
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic   cap;
        frame_t f;
        if (rst) begin
            mq.delete();
            midx       = 0;
            mdone_prev = 1'b0;
            mdrop      = 1'b0;
            mcnt       = 0;
        end else begin
            cap   = conv_done && !mdone_prev;
            mdrop = 1'b0;
            if (mq.size() != 0 && m_ready) begin
                if (midx == OUT_LEN - 1) begin
                    void'(mq.pop_front());
                    midx = 0;
                end else begin
                    midx++;
                end
            end
            if (cap) begin
                if (mq.size() < 2) begin
                    f.data = conv_in;
                    f.ovf  = conv_overflow;
                    mq.push_back(f);
                end else begin
                    mdrop = 1'b1;
                    if (mcnt < 255) mcnt++;
                end
            end
            mdone_prev = conv_done;
        end
    endtask

    task automatic step(input logic r, input logic d, input logic rdy,
                        input logic [BUS_W-1:0] data, input logic ovf);
        rst           = r;
        conv_done     = d;
        m_ready       = rdy;
        conv_in       = data;
        conv_overflow = ovf;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    logic [BUS_W-1:0] fa, fb, fc;
    logic [95:0]      rnd;
    logic             rd, rr, rdy;

    initial begin
        midx       = 0;
        mdone_prev = 1'b0;
        mdrop      = 1'b0;
        mcnt       = 0;
        fa = 80'h50_05_40_04_30_03_20_02_10_01;
        fb = {OUT_LEN{8'h7F, 8'h80}};
        fc = 80'hAA_55_AA_55_AA_55_AA_55_AA_55;
        rst = 1'b1; conv_done = 1'b0; m_ready = 1'b0; conv_in = '0; conv_overflow = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then a single frame with m_ready held high.
        step(1'b1, 1'b0, 1'b1, fa, 1'b0);
        step(1'b1, 1'b0, 1'b1, fa, 1'b0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        step(1'b0, 1'b0, 1'b1, fa, 1'b0);
        step(1'b0, 1'b1, 1'b1, fa, 1'b0);
        chk("lit_valid0", 32'(m_valid), 32'd1);
        chk("lit_re0", 32'(m_re), 32'h10);
        chk("lit_im0", 32'(m_im), 32'h01);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, fa, 1'b0);
        chk("lit_last", 32'(m_last), 32'd1);
        chk("lit_re4", 32'(m_re), 32'h50);
        chk("lit_im4", 32'(m_im), 32'h05);
        step(1'b0, 1'b1, 1'b1, fa, 1'b0);
        chk("lit_busy_end", 32'(busy), 32'd0);

        // Stalled consumer: A active (overflow set), B pending, C dropped.
        step(1'b0, 1'b0, 1'b0, fa, 1'b1);
        step(1'b0, 1'b1, 1'b0, fa, 1'b1);
        chk("lit_ovf", 32'(m_overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, fb, 1'b0);
        step(1'b0, 1'b1, 1'b0, fb, 1'b0);
        step(1'b0, 1'b0, 1'b0, fc, 1'b0);
        step(1'b0, 1'b1, 1'b0, fc, 1'b0);
        chk("lit_drop", 32'(frame_dropped), 32'd1);
`ifdef CONV_SER_DROP_CNT_EN
        chk("lit_drop_count", 32'(drop_count), 32'd1);
`endif
        step(1'b0, 1'b0, 1'b1, fc, 1'b0);
        chk("lit_drop_pulse", 32'(frame_dropped), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, fc, 1'b0);
        // A's last beat has completed; B's sample 0 follows with no bubble.
        chk("lit_b_valid", 32'(m_valid), 32'd1);
        chk("lit_b_re0", 32'(m_re), 32'h7F);
        chk("lit_b_im0", 32'(m_im), 32'h80);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, fc, 1'b0);

        // Randomized traffic against the model.
        rd = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rd = ~rd;
            rdy = ($urandom_range(0, 9) < 7);
            rr  = ($urandom_range(0, 299) == 0);
            step(rr, rd, rdy, rnd[BUS_W-1:0], rnd[95]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_complex_serializer.md
Name: conv_complex_serializer

Overview:
Output-side reader for conv_complex. Captures the packed complex convolution result bus and its overflow flag when conv_complex asserts done. Streams the result one complex sample per beat over a valid/ready interface to the downstream consumer (DMA/UART framer). Holds one frame in flight plus a one-deep pending frame so conv_complex can start the next run without waiting.

Parameters:
QI, 4, integer bits per real/imag word (signed fixed point, two's complement).
QF, 4, fractional bits per word.
NUM_ELEMS, 3, signal length fed to conv_complex; frame length OUT_LEN = NUM_ELEMS+2 (localparam).
IDX_W, 8, width of m_index; must satisfy 2^IDX_W >= OUT_LEN.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
conv_in  in  2*(QI+QF)*(NUM_ELEMS+2)  packed result from conv_complex.
conv_overflow  in  1  overflow flag from conv_complex, sampled together with conv_in.
conv_done  in  1  done level from conv_complex; a frame is taken on its rising edge.
m_valid  out  1  output beat valid.
m_ready  in  1  downstream accepts the beat.
m_re  out  QI+QF  real part of current sample.
m_im  out  QI+QF  imaginary part of current sample.
m_index  out  IDX_W  sample index within frame, 0..OUT_LEN-1.
m_last  out  1  high on the beat with m_index == OUT_LEN-1.
m_overflow  out  1  overflow flag of the frame being sent, constant across the frame.
busy  out  1  active frame present (state SEND).
frame_dropped  out  1  one-cycle pulse when an arriving frame is discarded.

Behaviour:
- Packing: sample k occupies conv_in[2*W*(k+1)-1 : 2*W*k], W = QI+QF. Real is in the upper W bits of the slot, imaginary in the lower W bits. Sample 0 is the least-significant slot and is sent first.
- Edge detect: register done_q, which resets to 0. Capture event = conv_done & ~done_q. conv_done already high at the first cycle after reset counts as an edge.
- Reset: all outputs 0. State IDLE, index 0, pending empty, done_q 0. Reset mid-frame discards the active and pending frames. m_valid is 0 in the cycle after rst is sampled.
- FSM IDLE: on a capture event, latch conv_in and conv_overflow into the active register, index 0, go to SEND. m_valid rises in the cycle after the edge is sampled (latency 1).
- FSM SEND: m_valid=1. m_re, m_im and m_index come from the active register slot at the current index.
  - Outputs are stable while m_valid & ~m_ready.
  - A beat completes on m_valid & m_ready, and the index increments.
  - On the beat with m_last: if pending is full, move pending to active, index 0, stay in SEND with no bubble. Otherwise go to IDLE.
- Capture event while in SEND:
  - If pending is empty, latch into pending.
  - If pending is full, keep the existing pending frame, discard the new one, and pulse frame_dropped.
- Simultaneous capture and last beat with pending empty: the new frame loads directly into active, index 0, SEND continues. No drop.
- Simultaneous capture and last beat with pending full: pending moves to active and the new frame goes to pending. No drop.
- m_ready while m_valid=0 is ignored. m_valid never depends combinationally on m_ready.
- No arithmetic on samples: bit-exact pass-through of the signed words.

Optional Feature:
- Macro: CONV_SER_DROP_CNT_EN.
- Defined: adds output port drop_count [7:0]. It increments on each frame_dropped pulse, saturates at 255, and is cleared only by rst.
- Undefined: the port and counter are absent, and frame_dropped alone reports drops.

Decomposition:
- Shared package conv_pkg: WORD_LENGTH = QI+QF, the slot-extract function (slot k -> {re, im}), and the FSM state encoding (IDLE, SEND), shared with conv_complex and its benches.
- One sub-module is natural: conv_frame_reg, a parameterised capture register holding the packed bus plus overflow bit, instantiated twice (active and pending).
- Slot mux and FSM stay in the top module.

Test Plan:
- Single frame, m_ready=1: conv_in = {50,05,40,04,30,03,20,02,10,01} (hex bytes, MS first), conv_overflow=0, conv_done raised at cycle 10 -> m_valid at cycle 11. Beats (re,im) = (10,01),(20,02),(30,03),(40,04),(50,05) on cycles 11-15, m_last at index 4. busy low at cycle 16.
- Backpressure: same frame, m_ready toggled 0,1,0,0,1... -> each sample held stable until accepted. Five beats total, no duplication or skip. m_overflow follows captured value 1 when conv_overflow=1.
- Pending frame: second conv_done edge at beat 2 of frame A with different data (all slots 7F/80) -> after A's last beat, B's sample 0 appears next cycle with no bubble. frame_dropped stays 0.
- Drop: third edge while A active and B pending -> frame_dropped pulses one cycle, C never appears, B sent intact. With CONV_SER_DROP_CNT_EN, drop_count=1.
- Coincident edge on last beat with pending empty: new frame streams from index 0 next cycle, no drop.
- Reset mid-frame: rst high during beat 2 -> m_valid=0 the next cycle, busy=0. A subsequent conv_done edge restarts at index 0 with new data.
